// File: rtl/icache_linefill_unit_pkg.sv
// Shared types and default sizing for the icache line-fill unit.
package icache_linefill_unit_pkg;

  localparam int unsigned LF_MSHR_ENTRY_NUM     = 8;
  localparam int unsigned LF_MSHR_IDX_W         = $clog2(LF_MSHR_ENTRY_NUM);
  localparam int unsigned LF_ADDR_WIDTH         = 32;
  localparam int unsigned LF_ICACHE_INDEX_WIDTH = 7;
  localparam int unsigned LF_BEAT_WIDTH         = 256;
  localparam int unsigned LF_BEATS_PER_LINE     = 2;
  localparam int unsigned LF_LINE_WIDTH         = LF_BEAT_WIDTH * LF_BEATS_PER_LINE;

  // One MSHR miss request as presented on the txreq interface.
  typedef struct packed {
    logic [LF_ADDR_WIDTH-1:0] addr;
    logic [LF_MSHR_IDX_W-1:0] entry_idx;
    logic                     way;
  } linefill_req_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } fill_state_t;

endpackage

// File: rtl/icache_linefill_issue_reg.sv
// Single-slot valid/ready register; accepts a new word in the same cycle
// the held word drains, so it sustains one transfer per cycle.
module icache_linefill_issue_reg
  import icache_linefill_unit_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         busy_q, busy_d;
  logic [W-1:0] data_q, data_d;

  assign in_rdy   = ~busy_q | out_rdy;
  assign out_vld  = busy_q;
  assign out_data = data_q;

  // Load on an input handshake, otherwise empty once the held word drains.
  always_comb begin
    busy_d = busy_q;
    data_d = data_q;
    if (in_vld && in_rdy) begin
      busy_d = 1'b1;
      data_d = in_data;
    end else if (out_rdy) begin
      busy_d = 1'b0;
    end
  end

  // Slot state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/icache_linefill_unit.sv
// Line-fill unit: forwards MSHR misses to the downstream bus, assembles the
// response beats into a line, writes it to the data RAM and pulses the
// owning MSHR entry's linefill_done.
module icache_linefill_unit
  import icache_linefill_unit_pkg::*;
#(
  parameter int unsigned MSHR_ENTRY_NUM     = LF_MSHR_ENTRY_NUM,
  parameter int unsigned MSHR_IDX_W         = $clog2(MSHR_ENTRY_NUM),
  parameter int unsigned ADDR_WIDTH         = LF_ADDR_WIDTH,
  parameter int unsigned ICACHE_INDEX_WIDTH = LF_ICACHE_INDEX_WIDTH,
  parameter int unsigned BEAT_WIDTH         = LF_BEAT_WIDTH,
  parameter int unsigned BEATS_PER_LINE     = LF_BEATS_PER_LINE,
  parameter int unsigned LINE_WIDTH         = BEAT_WIDTH * BEATS_PER_LINE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          txreq_vld,
  output logic                          txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]         txreq_addr,
  input  logic [MSHR_IDX_W-1:0]         txreq_entry_idx,
  input  logic                          txreq_way,
  output logic                          bus_req_vld,
  input  logic                          bus_req_rdy,
  output logic [ADDR_WIDTH-1:0]         bus_req_addr,
  output logic [MSHR_IDX_W-1:0]         bus_req_id,
  input  logic                          bus_rsp_vld,
  output logic                          bus_rsp_rdy,
  input  logic [MSHR_IDX_W-1:0]         bus_rsp_id,
  input  logic [BEAT_WIDTH-1:0]         bus_rsp_data,
  input  logic                          bus_rsp_last,
  output logic                          dataram_wr_vld,
  input  logic                          dataram_wr_rdy,
  output logic [ICACHE_INDEX_WIDTH-1:0] dataram_wr_index,
  output logic                          dataram_wr_way,
  output logic [LINE_WIDTH-1:0]         dataram_wr_data,
  output logic [MSHR_ENTRY_NUM-1:0]     linefill_done,
  output logic                          proto_err
);

  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam int unsigned OFFS_W     = $clog2(LINE_BYTES);
  localparam int unsigned CNT_W      = $clog2(BEATS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  fill_state_t                   state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MSHR_IDX_W-1:0]         id_q, id_d;
  logic [LINE_WIDTH-1:0]         line_q, line_d;
  logic                          rsp_rdy_q, rsp_rdy_d;
  logic                          wr_vld_q, wr_vld_d;
  logic [MSHR_ENTRY_NUM-1:0]     done_q, done_d;
  logic                          proto_err_q, proto_err_d;
  logic                          live_q;
  logic [MSHR_ENTRY_NUM-1:0]     valid_q, valid_d;
  logic [MSHR_ENTRY_NUM-1:0]     way_q, way_d;
  logic [ICACHE_INDEX_WIDTH-1:0] idx_q [MSHR_ENTRY_NUM];
  logic [ICACHE_INDEX_WIDTH-1:0] idx_d [MSHR_ENTRY_NUM];

  linefill_req_t req;
  logic          issue_in_rdy;
  logic          txreq_hs, rsp_hs, wr_hs;

  assign req = '{addr: txreq_addr, entry_idx: txreq_entry_idx, way: txreq_way};

  // live_q keeps txreq_rdy low while in reset.
  assign txreq_rdy = live_q & issue_in_rdy;
  assign txreq_hs  = txreq_vld & txreq_rdy;
  assign rsp_hs    = bus_rsp_vld & rsp_rdy_q;
  assign wr_hs     = wr_vld_q & dataram_wr_rdy;

  icache_linefill_issue_reg #(
    .W(ADDR_WIDTH + MSHR_IDX_W)
  ) u_issue (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (txreq_vld & live_q),
    .in_rdy   (issue_in_rdy),
    .in_data  ({req.addr & ALIGN_MASK, req.entry_idx}),
    .out_vld  (bus_req_vld),
    .out_rdy  (bus_req_rdy),
    .out_data ({bus_req_addr, bus_req_id})
  );

  assign bus_rsp_rdy      = rsp_rdy_q;
  assign dataram_wr_vld   = wr_vld_q;
  assign dataram_wr_data  = line_q;
  assign dataram_wr_index = idx_q[id_q];
  assign dataram_wr_way   = way_q[id_q];
  assign linefill_done    = done_q;
  assign proto_err        = proto_err_q;

  // Next-state for the fill FSM, line buffer and fill table.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    line_d      = line_q;
    done_d      = '0;
    proto_err_d = proto_err_q;
    valid_d     = valid_q;
    way_d       = way_q;
    idx_d       = idx_q;

    unique case (state_q)
      IDLE: begin
        if (rsp_hs) begin
          id_d                     = bus_rsp_id;
          line_d[BEAT_WIDTH-1:0]   = bus_rsp_data;
          cnt_d                    = CNT_W'(1);
          state_d                  = COLLECT;
          if (bus_rsp_last || !valid_q[bus_rsp_id]) proto_err_d = 1'b1;
        end
      end
      COLLECT: begin
        if (rsp_hs) begin
          line_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = bus_rsp_data;
          if (bus_rsp_last != (cnt_q == LAST_CNT)) proto_err_d = 1'b1;
          if (bus_rsp_id != id_q) proto_err_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (wr_hs) begin
          state_d       = IDLE;
          done_d[id_q]  = 1'b1;
          valid_d[id_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied after the done-clear so a same-entry reissue in the write
    // handshake cycle leaves the entry valid and is not flagged.
    if (txreq_hs) begin
      if (valid_d[txreq_entry_idx]) proto_err_d = 1'b1;
      valid_d[txreq_entry_idx] = 1'b1;
      way_d[txreq_entry_idx]   = txreq_way;
      idx_d[txreq_entry_idx]   = txreq_addr[OFFS_W +: ICACHE_INDEX_WIDTH];
    end

    rsp_rdy_d = (state_d != WRITE);
    wr_vld_d  = (state_d == WRITE);
  end

  // FSM, registered outputs and fill table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      line_q      <= '0;
      rsp_rdy_q   <= 1'b0;
      wr_vld_q    <= 1'b0;
      done_q      <= '0;
      proto_err_q <= 1'b0;
      live_q      <= 1'b0;
      valid_q     <= '0;
      way_q       <= '0;
      idx_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      line_q      <= line_d;
      rsp_rdy_q   <= rsp_rdy_d;
      wr_vld_q    <= wr_vld_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
      live_q      <= 1'b1;
      valid_q     <= valid_d;
      way_q       <= way_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_icache_linefill_unit.sv
// Directed self-checking bench for icache_linefill_unit.
module tb_icache_linefill_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         txreq_vld;
  logic         txreq_rdy;
  logic [31:0]  txreq_addr;
  logic [2:0]   txreq_entry_idx;
  logic         txreq_way;
  logic         bus_req_vld;
  logic         bus_req_rdy;
  logic [31:0]  bus_req_addr;
  logic [2:0]   bus_req_id;
  logic         bus_rsp_vld;
  logic         bus_rsp_rdy;
  logic [2:0]   bus_rsp_id;
  logic [255:0] bus_rsp_data;
  logic         bus_rsp_last;
  logic         dataram_wr_vld;
  logic         dataram_wr_rdy;
  logic [6:0]   dataram_wr_index;
  logic         dataram_wr_way;
  logic [511:0] dataram_wr_data;
  logic [7:0]   linefill_done;
  logic         proto_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  icache_linefill_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .txreq_vld        (txreq_vld),
    .txreq_rdy        (txreq_rdy),
    .txreq_addr       (txreq_addr),
    .txreq_entry_idx  (txreq_entry_idx),
    .txreq_way        (txreq_way),
    .bus_req_vld      (bus_req_vld),
    .bus_req_rdy      (bus_req_rdy),
    .bus_req_addr     (bus_req_addr),
    .bus_req_id       (bus_req_id),
    .bus_rsp_vld      (bus_rsp_vld),
    .bus_rsp_rdy      (bus_rsp_rdy),
    .bus_rsp_id       (bus_rsp_id),
    .bus_rsp_data     (bus_rsp_data),
    .bus_rsp_last     (bus_rsp_last),
    .dataram_wr_vld   (dataram_wr_vld),
    .dataram_wr_rdy   (dataram_wr_rdy),
    .dataram_wr_index (dataram_wr_index),
    .dataram_wr_way   (dataram_wr_way),
    .dataram_wr_data  (dataram_wr_data),
    .linefill_done    (linefill_done),
    .proto_err        (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one txreq for a single cycle (caller ensures the slot is free).
  task automatic issue(input logic [31:0] a, input logic [2:0] idx, input logic w);
    txreq_vld = 1'b1; txreq_addr = a; txreq_entry_idx = idx; txreq_way = w;
    tick();
    txreq_vld = 1'b0;
  endtask

  // Two back-to-back beats; returns in the cycle after the last beat.
  task automatic drive_line(input logic [2:0] id, input logic [255:0] b0, input logic [255:0] b1);
    bus_rsp_vld = 1'b1; bus_rsp_id = id; bus_rsp_data = b0; bus_rsp_last = 1'b0;
    tick();
    bus_rsp_data = b1; bus_rsp_last = 1'b1;
    tick();
    bus_rsp_vld = 1'b0; bus_rsp_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    txreq_vld = 0; txreq_addr = '0; txreq_entry_idx = '0; txreq_way = 0;
    bus_req_rdy = 0; bus_rsp_vld = 0; bus_rsp_id = '0; bus_rsp_data = '0; bus_rsp_last = 0;
    dataram_wr_rdy = 0;
    tick(); tick();
    checks++; if (txreq_rdy !== 1'b0) begin errors++; $display("FAIL reset_txreq_rdy got %b exp 0", txreq_rdy); end
    checks++; if (bus_req_vld !== 1'b0) begin errors++; $display("FAIL reset_bus_req_vld got %b exp 0", bus_req_vld); end
    checks++; if (bus_rsp_rdy !== 1'b0) begin errors++; $display("FAIL reset_bus_rsp_rdy got %b exp 0", bus_rsp_rdy); end
    checks++; if (dataram_wr_vld !== 1'b0) begin errors++; $display("FAIL reset_wr_vld got %b exp 0", dataram_wr_vld); end
    checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL reset_done got %h exp 00", linefill_done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    checks++; if (dataram_wr_data !== 512'd0) begin errors++; $display("FAIL reset_wr_data not zero"); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_txreq_rdy got %b exp 1", txreq_rdy); end
    checks++; if (bus_rsp_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rsp_rdy got %b exp 1", bus_rsp_rdy); end
  endtask

  task automatic test_single_miss();
    logic [255:0] a, b;
    a = {8{32'hA5A5_0001}}; b = {8{32'h5A5A_0002}};
    bus_req_rdy = 1'b1; dataram_wr_rdy = 1'b1;
    txreq_vld = 1'b1; txreq_addr = 32'h0000_1240; txreq_entry_idx = 3'd3; txreq_way = 1'b1;
    #1;
    checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL single_txreq_rdy got %b exp 1", txreq_rdy); end
    tick();
    txreq_vld = 1'b0;
    checks++; if (bus_req_vld !== 1'b1) begin errors++; $display("FAIL single_bus_vld got %b exp 1", bus_req_vld); end
    checks++; if (bus_req_addr !== 32'h0000_1240) begin errors++; $display("FAIL single_bus_addr got %h exp 00001240", bus_req_addr); end
    checks++; if (bus_req_id !== 3'd3) begin errors++; $display("FAIL single_bus_id got %0d exp 3", bus_req_id); end
    bus_rsp_vld = 1'b1; bus_rsp_id = 3'd3; bus_rsp_data = a; bus_rsp_last = 1'b0;
    #1;
    checks++; if (bus_rsp_rdy !== 1'b1) begin errors++; $display("FAIL single_rsp_rdy got %b exp 1", bus_rsp_rdy); end
    tick();
    checks++; if (bus_req_vld !== 1'b0) begin errors++; $display("FAIL single_bus_vld_drop got %b exp 0", bus_req_vld); end
    bus_rsp_data = b; bus_rsp_last = 1'b1;
    tick();
    bus_rsp_vld = 1'b0; bus_rsp_last = 1'b0;
    checks++; if (dataram_wr_vld !== 1'b1) begin errors++; $display("FAIL single_wr_vld got %b exp 1", dataram_wr_vld); end
    checks++; if (dataram_wr_data !== {b, a}) begin errors++; $display("FAIL single_wr_data got %h exp %h", dataram_wr_data, {b, a}); end
    checks++; if (dataram_wr_index !== 7'h49) begin errors++; $display("FAIL single_wr_index got %h exp 49", dataram_wr_index); end
    checks++; if (dataram_wr_way !== 1'b1) begin errors++; $display("FAIL single_wr_way got %b exp 1", dataram_wr_way); end
    checks++; if (bus_rsp_rdy !== 1'b0) begin errors++; $display("FAIL single_rsp_rdy_write got %b exp 0", bus_rsp_rdy); end
    checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL single_done_early got %h exp 00", linefill_done); end
    tick();
    checks++; if (linefill_done !== 8'h08) begin errors++; $display("FAIL single_done got %h exp 08", linefill_done); end
    checks++; if (dataram_wr_vld !== 1'b0) begin errors++; $display("FAIL single_wr_vld_drop got %b exp 0", dataram_wr_vld); end
    tick();
    checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL single_done_width got %h exp 00", linefill_done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_backpressure();
    logic [255:0] a, b;
    a = {8{32'h1111_2222}}; b = {8{32'h3333_4444}};
    bus_req_rdy = 1'b0; dataram_wr_rdy = 1'b1;
    issue(32'h0000_2080, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus_req_vld !== 1'b1) begin errors++; $display("FAIL bp_bus_vld[%0d] got %b exp 1", i, bus_req_vld); end
      checks++; if (bus_req_addr !== 32'h0000_2080) begin errors++; $display("FAIL bp_bus_addr[%0d] got %h exp 00002080", i, bus_req_addr); end
      checks++; if (bus_req_id !== 3'd1) begin errors++; $display("FAIL bp_bus_id[%0d] got %0d exp 1", i, bus_req_id); end
      checks++; if (txreq_rdy !== 1'b0) begin errors++; $display("FAIL bp_txreq_rdy[%0d] got %b exp 0", i, txreq_rdy); end
      tick();
    end
    bus_req_rdy = 1'b1;
    #1;
    checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL bp_txreq_rdy_drain got %b exp 1", txreq_rdy); end
    tick();
    checks++; if (bus_req_vld !== 1'b0) begin errors++; $display("FAIL bp_bus_vld_drop got %b exp 0", bus_req_vld); end
    dataram_wr_rdy = 1'b0;
    drive_line(3'd1, a, b);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dataram_wr_vld !== 1'b1) begin errors++; $display("FAIL bp_wr_vld[%0d] got %b exp 1", i, dataram_wr_vld); end
      checks++; if (bus_rsp_rdy !== 1'b0) begin errors++; $display("FAIL bp_rsp_rdy[%0d] got %b exp 0", i, bus_rsp_rdy); end
      checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL bp_done_early[%0d] got %h exp 00", i, linefill_done); end
      tick();
    end
    dataram_wr_rdy = 1'b1;
    checks++; if (dataram_wr_index !== 7'h02) begin errors++; $display("FAIL bp_wr_index got %h exp 02", dataram_wr_index); end
    checks++; if (dataram_wr_data !== {b, a}) begin errors++; $display("FAIL bp_wr_data got %h exp %h", dataram_wr_data, {b, a}); end
    tick();
    checks++; if (linefill_done !== 8'h02) begin errors++; $display("FAIL bp_done got %h exp 02", linefill_done); end
    checks++; if (bus_rsp_rdy !== 1'b1) begin errors++; $display("FAIL bp_rsp_rdy_back got %b exp 1", bus_rsp_rdy); end
  endtask

  task automatic test_interleaved();
    logic [2:0]  ids   [3] = '{3'd0, 3'd5, 3'd7};
    logic [31:0] addrs [3] = '{32'h0000_0040, 32'h0000_3FC0, 32'h0001_0100};
    logic        ways  [3] = '{1'b0, 1'b1, 1'b1};
    logic [6:0]  xidx  [3] = '{7'h01, 7'h7F, 7'h04};
    logic [7:0]  xdone [3] = '{8'h01, 8'h20, 8'h80};
    int          order [3] = '{2, 0, 1};
    logic [255:0] b0, b1;
    bus_req_rdy = 1'b1; dataram_wr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txreq_vld = 1'b1; txreq_addr = addrs[i]; txreq_entry_idx = ids[i]; txreq_way = ways[i];
      #1;
      checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL il_txreq_rdy[%0d] got %b exp 1", i, txreq_rdy); end
      tick();
      checks++; if (bus_req_vld !== 1'b1) begin errors++; $display("FAIL il_bus_vld[%0d] got %b exp 1", i, bus_req_vld); end
      checks++; if (bus_req_id !== ids[i]) begin errors++; $display("FAIL il_bus_id[%0d] got %0d exp %0d", i, bus_req_id, ids[i]); end
      checks++; if (bus_req_addr !== addrs[i]) begin errors++; $display("FAIL il_bus_addr[%0d] got %h exp %h", i, bus_req_addr, addrs[i]); end
    end
    txreq_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int j;
      j  = order[k];
      b0 = {8{24'hB0B0B0, 5'd0, ids[j]}};
      b1 = {8{24'hC1C1C1, 5'd0, ids[j]}};
      drive_line(ids[j], b0, b1);
      checks++; if (dataram_wr_vld !== 1'b1) begin errors++; $display("FAIL il_wr_vld[%0d] got %b exp 1", k, dataram_wr_vld); end
      checks++; if (dataram_wr_index !== xidx[j]) begin errors++; $display("FAIL il_wr_index[%0d] got %h exp %h", k, dataram_wr_index, xidx[j]); end
      checks++; if (dataram_wr_way !== ways[j]) begin errors++; $display("FAIL il_wr_way[%0d] got %b exp %b", k, dataram_wr_way, ways[j]); end
      checks++; if (dataram_wr_data !== {b1, b0}) begin errors++; $display("FAIL il_wr_data[%0d] got %h exp %h", k, dataram_wr_data, {b1, b0}); end
      tick();
      checks++; if (linefill_done !== xdone[j]) begin errors++; $display("FAIL il_done[%0d] got %h exp %h", k, linefill_done, xdone[j]); end
    end
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL il_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_reissue();
    logic [255:0] a, b, c, d;
    a = {8{32'hDEAD_0001}}; b = {8{32'hDEAD_0002}};
    c = {8{32'hBEEF_0003}}; d = {8{32'hBEEF_0004}};
    bus_req_rdy = 1'b1; dataram_wr_rdy = 1'b1;
    issue(32'h0000_0500, 3'd2, 1'b0);
    drive_line(3'd2, a, b);
    txreq_vld = 1'b1; txreq_addr = 32'h0000_0A00; txreq_entry_idx = 3'd2; txreq_way = 1'b1;
    #1;
    checks++; if (txreq_rdy !== 1'b1) begin errors++; $display("FAIL ri_txreq_rdy got %b exp 1", txreq_rdy); end
    checks++; if (dataram_wr_index !== 7'h14) begin errors++; $display("FAIL ri_wr_index1 got %h exp 14", dataram_wr_index); end
    tick();
    txreq_vld = 1'b0;
    checks++; if (linefill_done !== 8'h04) begin errors++; $display("FAIL ri_done1 got %h exp 04", linefill_done); end
    checks++; if (bus_req_addr !== 32'h0000_0A00) begin errors++; $display("FAIL ri_bus_addr got %h exp 00000a00", bus_req_addr); end
    drive_line(3'd2, c, d);
    checks++; if (dataram_wr_index !== 7'h28) begin errors++; $display("FAIL ri_wr_index2 got %h exp 28", dataram_wr_index); end
    checks++; if (dataram_wr_way !== 1'b1) begin errors++; $display("FAIL ri_wr_way2 got %b exp 1", dataram_wr_way); end
    checks++; if (dataram_wr_data !== {d, c}) begin errors++; $display("FAIL ri_wr_data2 got %h exp %h", dataram_wr_data, {d, c}); end
    tick();
    checks++; if (linefill_done !== 8'h04) begin errors++; $display("FAIL ri_done2 got %h exp 04", linefill_done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ri_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_proto_err();
    logic [255:0] a, b;
    a = {8{32'h0BAD_0001}}; b = {8{32'h0BAD_0002}};
    bus_req_rdy = 1'b1; dataram_wr_rdy = 1'b1;
    issue(32'h0000_0100, 3'd6, 1'b0);
    bus_rsp_vld = 1'b1; bus_rsp_id = 3'd6; bus_rsp_data = a; bus_rsp_last = 1'b1;
    tick();
    bus_rsp_data = b;
    tick();
    bus_rsp_vld = 1'b0; bus_rsp_last = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_last_beat0 got %b exp 1", proto_err); end
    checks++; if (dataram_wr_index !== 7'h04) begin errors++; $display("FAIL pe_wr_index got %h exp 04", dataram_wr_index); end
    tick();
    checks++; if (linefill_done !== 8'h40) begin errors++; $display("FAIL pe_done1 got %h exp 40", linefill_done); end
    drive_line(3'd4, b, a);
    checks++; if (dataram_wr_data !== {a, b}) begin errors++; $display("FAIL pe_wr_data2 got %h exp %h", dataram_wr_data, {a, b}); end
    tick();
    checks++; if (linefill_done !== 8'h10) begin errors++; $display("FAIL pe_done2 got %h exp 10", linefill_done); end
    tick(); tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_sticky got %b exp 1", proto_err); end
  endtask

  task automatic test_reset_mid_collect();
    logic [255:0] junk, c, d;
    junk = {8{32'hFFFF_EEEE}}; c = {8{32'h7777_0001}}; d = {8{32'h7777_0002}};
    bus_req_rdy = 1'b1; dataram_wr_rdy = 1'b1;
    issue(32'h0000_0C00, 3'd1, 1'b0);
    bus_rsp_vld = 1'b1; bus_rsp_id = 3'd1; bus_rsp_data = junk; bus_rsp_last = 1'b0;
    tick();
    bus_rsp_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rm_rsp_rdy got %b exp 0", bus_rsp_rdy); end
    checks++; if (txreq_rdy !== 1'b0) begin errors++; $display("FAIL rm_txreq_rdy got %b exp 0", txreq_rdy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rm_proto_err got %b exp 0", proto_err); end
    checks++; if (dataram_wr_data !== 512'd0) begin errors++; $display("FAIL rm_wr_data not zero"); end
    checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL rm_done got %h exp 00", linefill_done); end
    tick(); tick();
    checks++; if (linefill_done !== 8'h00) begin errors++; $display("FAIL rm_done_held got %h exp 00", linefill_done); end
    rst_n = 1'b1;
    tick(); tick();
    issue(32'h0000_0C40, 3'd1, 1'b1);
    drive_line(3'd1, c, d);
    checks++; if (dataram_wr_data !== {d, c}) begin errors++; $display("FAIL rm_wr_data2 got %h exp %h", dataram_wr_data, {d, c}); end
    checks++; if (dataram_wr_index !== 7'h31) begin errors++; $display("FAIL rm_wr_index got %h exp 31", dataram_wr_index); end
    checks++; if (dataram_wr_way !== 1'b1) begin errors++; $display("FAIL rm_wr_way got %b exp 1", dataram_wr_way); end
    tick();
    checks++; if (linefill_done !== 8'h02) begin errors++; $display("FAIL rm_done2 got %h exp 02", linefill_done); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rm_proto_err2 got %b exp 0", proto_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_miss();
    test_backpressure();
    test_interleaved();
    test_reissue();
    test_proto_err();
    test_reset_mid_collect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_linefill_unit.md
Name: icache_linefill_unit

Overview:
- Downstream responder for the icache MSHR entries: accepts each entry's miss request (txreq), issues it on the downstream bus and collects the response beats into a full cache line.
- Writes the assembled line into the data RAM, then pulses linefill_done to the owning MSHR entry.
- Sits between the MSHR entry array and the L2/memory port.

Parameters:
- MSHR_ENTRY_NUM, 8, number of MSHR entries; one outstanding fill per entry.
- MSHR_IDX_W, $clog2(MSHR_ENTRY_NUM), entry id width.
- ADDR_WIDTH, 32, request address width.
- ICACHE_INDEX_WIDTH, 7, data RAM set index width.
- BEAT_WIDTH, 256, downstream response data width.
- BEATS_PER_LINE, 2, beats per cache line (power of two, >=2).
- LINE_WIDTH, BEAT_WIDTH*BEATS_PER_LINE, cache line width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- txreq_vld  in  1  MSHR miss request valid
- txreq_rdy  out  1  request accepted
- txreq_addr  in  ADDR_WIDTH  line address
- txreq_entry_idx  in  MSHR_IDX_W  requesting MSHR entry
- txreq_way  in  1  victim way for the fill
- bus_req_vld  out  1  downstream read request valid
- bus_req_rdy  in  1  downstream ready
- bus_req_addr  out  ADDR_WIDTH  line-aligned address
- bus_req_id  out  MSHR_IDX_W  transaction id (= entry idx)
- bus_rsp_vld  in  1  response beat valid
- bus_rsp_rdy  out  1  beat accepted
- bus_rsp_id  in  MSHR_IDX_W  response transaction id
- bus_rsp_data  in  BEAT_WIDTH  beat data
- bus_rsp_last  in  1  final beat of line
- dataram_wr_vld  out  1  line write valid
- dataram_wr_rdy  in  1  data RAM accepts write
- dataram_wr_index  out  ICACHE_INDEX_WIDTH  set index from stored addr
- dataram_wr_way  out  1  stored victim way
- dataram_wr_data  out  LINE_WIDTH  assembled line, beat 0 in LSBs
- linefill_done  out  MSHR_ENTRY_NUM  one-hot, one-cycle done pulse per entry
- proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0, FSM in IDLE, table valid bits 0, beat counter 0, issue register empty, proto_err 0. A reset mid-fill discards all state; no done pulse is issued.
- Fill table: per entry {valid, addr, way}. Written on a txreq handshake at entry txreq_entry_idx. Cleared in the cycle the linefill_done pulse is registered.
- Issue register: one slot. txreq_rdy = ~issue_busy | bus_req_rdy.
  - Request accepted in cycle N -> bus_req_vld=1 in cycle N+1, held with stable addr/id until bus_req_rdy.
  - Back-to-back requests sustain one per cycle.
- bus_req_addr = txreq_addr with the line-offset bits zeroed.
- Fill FSM, responses for one id arrive contiguously:
  - IDLE: bus_rsp_rdy=1. On a beat handshake: latch id, store beat 0, cnt=1, go to COLLECT. If BEATS_PER_LINE had last set on beat 0, that is a proto_err (see below).
  - COLLECT: bus_rsp_rdy=1. Each beat is stored at slot cnt, cnt++. When the accepted beat has cnt==BEATS_PER_LINE-1, go to WRITE.
  - WRITE: bus_rsp_rdy=0. dataram_wr_vld=1; index and way come from table[id].
    - On dataram_wr_rdy: go to IDLE and register linefill_done[id]=1 for exactly one cycle (handshake cycle K -> pulse in K+1).
    - The table entry is cleared with the pulse.
- Latency: last beat accepted in cycle M -> dataram_wr_vld=1 in M+1.
  - Zero-wait minimum: pulse in M+2.
  - The next line's beat 0 is accepted no earlier than M+2.
- Protocol errors set proto_err (sticky until reset); the fill still completes:
  - bus_rsp_last disagrees with cnt==BEATS_PER_LINE-1
  - bus_rsp_id changes mid-line
  - response for an id whose table entry is invalid
  - txreq to an entry already valid
- Simultaneous events:
  - A txreq handshake and linefill_done for different entries proceed independently.
  - For the same entry, txreq in the pulse cycle is legal: the clear happens first, then the new write, so the entry stays valid with the new request.
- Beat counter width: $clog2(BEATS_PER_LINE). It wraps to 0 on entry to WRITE.

Decomposition:
- toy_pack additions: linefill_req_t {addr, entry_idx, way}, fill_state_t {IDLE, COLLECT, WRITE}, and the BEATS_PER_LINE/LINE_WIDTH constants.
- One natural sub-module: icache_linefill_issue_reg, the single-slot valid/ready pipeline register driving bus_req.

Test Plan:
- Single miss: txreq addr=0x0000_1240, idx=3, way=1; bus_req_rdy=1 -> bus_req in next cycle with addr=0x0000_1240 (64B line), id=3. Return 2 beats A,B -> dataram_wr_data={B,A}, index=0x49, way=1; linefill_done=8'b0000_1000 for 1 cycle.
- Backpressure: bus_req_rdy=0 for 5 cycles -> bus_req_vld/addr held stable, txreq_rdy=0 while the slot is full; dataram_wr_rdy=0 for 3 cycles -> bus_rsp_rdy=0 and no done pulse until the write handshake.
- Interleaved fills: entries 0,5,7 issued back-to-back at 1/cycle; responses return in order 7,0,5 -> done pulses 0x80, 0x01, 0x20 with the correct stored index/way each.
- Reissue in pulse cycle: txreq idx=2 in the same cycle as linefill_done[2] -> table[2] stays valid with the new addr, second fill completes normally, proto_err=0.
- Protocol errors: bus_rsp_last on beat 0, or a response to an invalid id=4 -> proto_err=1 and it stays 1; fill still produces a done pulse.
- Reset mid-COLLECT after 1 beat: assert rst_n=0 -> all outputs 0; after release, a new fill completes with no stale beat data.
